apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
- Single-outstanding APB3 requester that converts a valid/ready command interface into APB SETUP/ACCESS transfers.
- Drives the team's 16-bit APB register blocks (ctrl/status/cmd/config at 0x00/0x04/0x08/0x0C) from firmware/test sequencers.
- Returns read data, PSLVERR and a wait-state timeout flag on a held response channel.

Parameters:
- ADDR_W, 8, APB address width
- DATA_W, 16, APB data width
- TIMEOUT, 16, maximum ACCESS cycles waiting for PREADY; 0 disables timeout

Ports:
- PCLK  in  1  clock
- PRESETn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid&ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  response held until rsp_ready
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_W  read data (0 for writes and timeouts)
- rsp_err  out  1  PSLVERR seen or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB error

Behaviour:
- Interface: one clock PCLK; reset PRESETn is asynchronous, active-low.
- All outputs are registered except cmd_ready, which is decoded from state.
- Reset values: state IDLE; PSEL, PENABLE, PWRITE, rsp_valid, rsp_err and rsp_timeout are 0; PADDR, PWDATA and rsp_rdata are all-zero; the timeout counter is 0.
- FSM IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch write/addr/wdata into PWRITE/PADDR/PWDATA, set PSEL=1, and go to SETUP.
- FSM SETUP:
  - PSEL=1, PENABLE=0.
  - Unconditional next state ACCESS; set PENABLE=1 and clear the counter.
- FSM ACCESS:
  - PSEL=1, PENABLE=1; the counter increments each cycle while PREADY=0.
  - PREADY=1: capture PRDATA into rsp_rdata for reads (0 for writes), rsp_err=PSLVERR, rsp_timeout=0, drop PSEL/PENABLE, go to RESP.
  - PREADY=0 with TIMEOUT!=0 and counter==TIMEOUT-1: rsp_rdata=0, rsp_err=1, rsp_timeout=1, drop PSEL/PENABLE, go to RESP.
  - PREADY and the timeout in the same cycle: PREADY wins, and the transfer completes normally.
- FSM RESP:
  - rsp_valid=1, cmd_ready=0.
  - On rsp_ready, clear rsp_valid and go to IDLE.
- Latency:
  - Command accepted at cycle N (IDLE, valid&ready).
  - SETUP visible on the bus in N+1, ACCESS in N+2.
  - With zero wait states, rsp_valid in N+3.
  - Next command accepted no earlier than the cycle after the rsp_ready handshake; minimum 4 cycles per transfer.
- PADDR/PWRITE/PWDATA:
  - Stable from SETUP through the last ACCESS cycle.
  - Hold their last value while idle; no X-propagation.
- rsp_rdata/rsp_err/rsp_timeout: stable while rsp_valid=1.
- Counter: width $clog2(TIMEOUT+1), minimum 1 bit; saturates and never wraps.
- Reset mid-transfer: PSEL/PENABLE drop asynchronously, any pending response is discarded, and the state returns to IDLE.
- cmd_* inputs are ignored outside IDLE.

Decomposition:
- Shared package apb_pkg holds:
  - state enum (IDLE, SETUP, ACCESS, RESP)
  - register address constants: ADDR_CTRL 0x00, ADDR_STATUS 0x04, ADDR_CMD 0x08, ADDR_CONFIG 0x0C
  - read-miss value 0xDEAD
- No sub-module needed; the timeout counter is inline.

Test Plan:
- Write 0x00 ← 0x1234 to the register block, then read 0x00 -> PSEL/PENABLE sequence 10 then 11 with PADDR=0x00; read rsp_rdata=0x1234, rsp_err=0; rsp_valid at N+3 for each transfer.
- Read 0x04 -> rsp_rdata=0x0002. Read 0x08 (write-only) -> rsp_rdata=0xDEAD. Read 0x0C after reset -> 0x00A5.
- Bench slave holds PREADY=0 for 3 ACCESS cycles on a write of 0x5A5A to 0x0C -> PENABLE high 4 cycles; PADDR/PWDATA stable throughout; rsp_valid at N+6.
- TIMEOUT=8, slave never asserts PREADY -> exactly 8 ACCESS cycles, then PSEL=0; rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- PSLVERR=1 with PREADY=1 on a read -> rsp_err=1, rsp_timeout=0. Hold rsp_ready=0 for 5 cycles -> rsp_valid and data held, cmd_ready=0, no new SETUP.
- Assert PRESETn=0 mid-ACCESS -> PSEL/PENABLE are 0 in the same cycle, rsp_valid=0, and after release cmd_ready=1.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: requester FSM states, register-block address map
// and the value the register block returns for unmapped or write-only reads.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [7:0]  ADDR_CTRL   = 8'h00;
    localparam logic [7:0]  ADDR_STATUS = 8'h04;
    localparam logic [7:0]  ADDR_CMD    = 8'h08;
    localparam logic [7:0]  ADDR_CONFIG = 8'h0C;

    localparam logic [15:0] READ_MISS   = 16'hDEAD;

endpackage

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB3 requester: a valid/ready command becomes one
// SETUP/ACCESS transfer, and the result is held on the response channel
// until consumed. A wait-state counter aborts transfers whose slave never
// raises PREADY (TIMEOUT=0 disables the abort).
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit TO_EN = (TIMEOUT != 0);
    // Counter value seen in the last ACCESS cycle the slave is allowed
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;

    // Saturating increment so a disabled or oversized wait never wraps
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    assign cmd_ready   = (state == IDLE);
    assign timeout_hit = TO_EN && (wait_cnt == CNT_LAST);

    // Transfer FSM with registered bus, response and wait-counter outputs
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state       <= IDLE;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        PWRITE <= cmd_write;
                        PADDR  <= cmd_addr;
                        PWDATA <= cmd_wdata;
                        PSEL   <= 1'b1;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    // A slave answering in the timeout cycle still completes normally
                    if (PREADY) begin
                        rsp_rdata   <= PWRITE ? '0 : PRDATA;
                        rsp_err     <= PSLVERR;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        state       <= RESP;
                    end else if (timeout_hit) begin
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        state       <= RESP;
                    end else begin
                        wait_cnt <= sat_inc(wait_cnt);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: behavioural 16-bit register block as APB slave,
// a table of directed transfers, reset/abort sequences and random transfers
// checked against an address-map model.
module tb_apb_master_bridge;
    import apb_pkg::*;

    localparam int TO = 8;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [7:0]  cmd_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_rdata;
    logic        rsp_err, rsp_timeout;
    logic        PSEL, PENABLE, PWRITE;
    logic [7:0]  PADDR;
    logic [15:0] PWDATA, PRDATA;
    logic        PREADY, PSLVERR;

    int n_checks = 0;
    int n_fail   = 0;

    apb_master_bridge #(.ADDR_W(8), .DATA_W(16), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    // ---------------- behavioural register-block slave ----------------
    int          sl_waits = 0;
    logic        sl_err   = 1'b0;
    int          acc_cnt;
    logic [15:0] sl_ctrl, sl_cfg;

    always_comb begin
        PREADY  = PSEL && PENABLE && (acc_cnt >= sl_waits);
        PSLVERR = PREADY && sl_err;
        case (PADDR)
            ADDR_CTRL:   PRDATA = sl_ctrl;
            ADDR_STATUS: PRDATA = 16'h0002;
            ADDR_CONFIG: PRDATA = sl_cfg;
            default:     PRDATA = READ_MISS;
        endcase
    end

    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            acc_cnt <= 0;
            sl_ctrl <= 16'h0000;
            sl_cfg  <= 16'h00A5;
        end else begin
            if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
            else                            acc_cnt <= 0;
            if (PSEL && PENABLE && PREADY && PWRITE && !PSLVERR) begin
                if (PADDR == ADDR_CTRL)   sl_ctrl <= PWDATA;
                if (PADDR == ADDR_CONFIG) sl_cfg  <= PWDATA;
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // One complete transfer with protocol, latency and response-hold checks
    task automatic xfer(input logic wr, input logic [7:0] addr, input logic [15:0] wd,
                        input int waits, input logic err, input int hold,
                        input logic [15:0] e_rd, input logic e_err, input logic e_to,
                        input int e_lat, input int e_acc);
        int cyc;
        int acc;
        bit got;
        sl_waits = waits;
        sl_err   = err;
        check("idle cmd_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
        tick();
        cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = 8'($urandom); cmd_wdata = 16'($urandom);
        check("setup psel/penable", 32'({PSEL, PENABLE}), 32'd2);
        check("setup paddr", 32'(PADDR), 32'(addr));
        check("setup pwrite", 32'(PWRITE), 32'(wr));
        check("setup pwdata", 32'(PWDATA), 32'(wd));
        cyc = 1; acc = 0; got = 0;
        while (!got && cyc < 40) begin
            tick();
            cyc++;
            if (rsp_valid) got = 1;
            else begin
                acc++;
                check("access psel/penable", 32'({PSEL, PENABLE}), 32'd3);
                check("access paddr stable", 32'(PADDR), 32'(addr));
                check("access pwdata stable", 32'(PWDATA), 32'(wd));
                check("access cmd_ready", 32'(cmd_ready), 32'd0);
            end
        end
        check("rsp_valid seen", 32'(got), 32'd1);
        check("rsp latency", 32'(cyc), 32'(e_lat));
        check("access cycles", 32'(acc), 32'(e_acc));
        check("resp bus idle", 32'({PSEL, PENABLE}), 32'd0);
        check("rsp_rdata", 32'(rsp_rdata), 32'(e_rd));
        check("rsp_err", 32'(rsp_err), 32'(e_err));
        check("rsp_timeout", 32'(rsp_timeout), 32'(e_to));
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1; cmd_addr = 8'($urandom); cmd_write = 1'($urandom);
            tick();
            check("hold rsp_valid", 32'(rsp_valid), 32'd1);
            check("hold rsp_rdata", 32'(rsp_rdata), 32'(e_rd));
            check("hold rsp_err", 32'({rsp_err, rsp_timeout}), 32'({e_err, e_to}));
            check("hold cmd_ready", 32'(cmd_ready), 32'd0);
            check("hold no setup", 32'({PSEL, PENABLE}), 32'd0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("after hs rsp_valid", 32'(rsp_valid), 32'd0);
        check("after hs cmd_ready", 32'(cmd_ready), 32'd1);
        check("after hs psel", 32'(PSEL), 32'd0);
    endtask

    // ---------------- address-map reference model ----------------
    logic [15:0] m_ctrl, m_cfg;

    function automatic logic [15:0] model_read(input logic [7:0] a);
        if (a == ADDR_CTRL)   return m_ctrl;
        if (a == ADDR_STATUS) return 16'h0002;
        if (a == ADDR_CONFIG) return m_cfg;
        return READ_MISS;
    endfunction

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [15:0] wd;
        int          waits;
        logic        err;
        int          hold;
        logic [15:0] rd;
        logic        e_err;
        logic        e_to;
        int          lat;
        int          acc;
    } vec_t;

    vec_t tbl[12];
    logic [7:0] addrs[4];

    initial begin
        PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; rsp_ready = 1'b0;
        addrs[0] = ADDR_CTRL; addrs[1] = ADDR_STATUS; addrs[2] = ADDR_CMD; addrs[3] = ADDR_CONFIG;

        //          wr    addr         wdata     wt  err  hld  rdata     err   to    lat acc
        tbl[0]  = '{1'b1, ADDR_CTRL,   16'h1234, 0,  1'b0, 0, 16'h0000, 1'b0, 1'b0, 3,  1};
        tbl[1]  = '{1'b0, ADDR_CTRL,   16'h0000, 0,  1'b0, 0, 16'h1234, 1'b0, 1'b0, 3,  1};
        tbl[2]  = '{1'b0, ADDR_STATUS, 16'h0000, 0,  1'b0, 0, 16'h0002, 1'b0, 1'b0, 3,  1};
        tbl[3]  = '{1'b0, ADDR_CMD,    16'h0000, 0,  1'b0, 0, 16'hDEAD, 1'b0, 1'b0, 3,  1};
        tbl[4]  = '{1'b0, ADDR_CONFIG, 16'h0000, 0,  1'b0, 0, 16'h00A5, 1'b0, 1'b0, 3,  1};
        tbl[5]  = '{1'b1, ADDR_CONFIG, 16'h5A5A, 3,  1'b0, 0, 16'h0000, 1'b0, 1'b0, 6,  4};
        tbl[6]  = '{1'b0, ADDR_CONFIG, 16'h0000, 0,  1'b0, 1, 16'h5A5A, 1'b0, 1'b0, 3,  1};
        tbl[7]  = '{1'b0, ADDR_STATUS, 16'h0000, 8,  1'b0, 0, 16'h0000, 1'b1, 1'b1, 10, 8};
        tbl[8]  = '{1'b0, ADDR_CTRL,   16'h0000, 7,  1'b0, 0, 16'h1234, 1'b0, 1'b0, 10, 8};
        tbl[9]  = '{1'b0, ADDR_CTRL,   16'h0000, 0,  1'b1, 5, 16'h1234, 1'b1, 1'b0, 3,  1};
        tbl[10] = '{1'b1, ADDR_CTRL,   16'hBEEF, 0,  1'b1, 0, 16'h0000, 1'b1, 1'b0, 3,  1};
        tbl[11] = '{1'b0, ADDR_CTRL,   16'h0000, 2,  1'b0, 0, 16'h1234, 1'b0, 1'b0, 5,  3};

        // Reset values while PRESETn is held low
        tick(); tick();
        check("rst psel/penable", 32'({PSEL, PENABLE}), 32'd0);
        check("rst pwrite", 32'(PWRITE), 32'd0);
        check("rst paddr", 32'(PADDR), 32'd0);
        check("rst pwdata", 32'(PWDATA), 32'd0);
        check("rst rsp flags", 32'({rsp_valid, rsp_err, rsp_timeout}), 32'd0);
        check("rst rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst cmd_ready", 32'(cmd_ready), 32'd1);
        PRESETn = 1'b1;
        tick();

        // Directed table
        foreach (tbl[i])
            xfer(tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].waits, tbl[i].err, tbl[i].hold,
                 tbl[i].rd, tbl[i].e_err, tbl[i].e_to, tbl[i].lat, tbl[i].acc);

        // Address and data hold their last value while idle
        tick(); tick();
        check("idle paddr hold", 32'(PADDR), 32'(ADDR_CTRL));
        check("idle psel", 32'(PSEL), 32'd0);

        // Reset in the middle of an ACCESS phase
        sl_waits = 255; sl_err = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = ADDR_STATUS;
        tick();
        cmd_valid = 1'b0;
        tick();
        check("pre-reset access", 32'({PSEL, PENABLE}), 32'd3);
        #2 PRESETn = 1'b0;
        #1;
        check("async rst psel/penable", 32'({PSEL, PENABLE}), 32'd0);
        check("async rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("async rst cmd_ready", 32'(cmd_ready), 32'd1);
        tick();
        PRESETn = 1'b1;
        tick();
        check("post rst cmd_ready", 32'(cmd_ready), 32'd1);
        check("post rst bus idle", 32'({PSEL, PENABLE, rsp_valid}), 32'd0);

        // Random transfers against the address-map model
        m_ctrl = 16'h0000;
        m_cfg  = 16'h00A5;
        for (int n = 0; n < 40; n++) begin
            logic        wr, err;
            logic [7:0]  a;
            logic [15:0] wd, e_rd;
            int          w, hold;
            wr   = 1'($urandom_range(0, 1));
            a    = addrs[$urandom_range(0, 3)];
            wd   = 16'($urandom);
            w    = $urandom_range(0, 9);
            err  = ($urandom_range(0, 5) == 0);
            hold = $urandom_range(0, 3);
            if (w >= TO) begin
                xfer(wr, a, wd, w, err, hold, 16'h0000, 1'b1, 1'b1, 2 + TO, TO);
            end else begin
                e_rd = wr ? 16'h0000 : model_read(a);
                xfer(wr, a, wd, w, err, hold, e_rd, err, 1'b0, 3 + w, w + 1);
                if (wr && !err) begin
                    if (a == ADDR_CTRL)   m_ctrl = wd;
                    if (a == ADDR_CONFIG) m_cfg  = wd;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
